// File: rtl/dsp_fir_sequencer.sv
// dsp_fir_sequencer: drives an external DSP MAC through a 4-tap FIR, one tap
// per cycle, and returns the accumulated result over a valid/ready port.
// Optional build macro: DSP_FIR_SEQ_SATURATE_EN clamps the result to the
// signed 20-bit range before it is registered.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a sample; a handshake shifts the delay line
//   MAC   | issues taps 0..3 to the DSP, one per cycle
//   WAIT  | lets the last tap drain through the DSP pipeline
//   OUT   | result held on m_data_o until m_ready_i accepts it
module dsp_fir_sequencer #(
  parameter logic signed [17:0] COEFF_0     = 18'sd0,
  parameter logic signed [17:0] COEFF_1     = 18'sd0,
  parameter logic signed [17:0] COEFF_2     = 18'sd0,
  parameter logic signed [17:0] COEFF_3     = 18'sd0,
  parameter int                 DSP_LATENCY = 1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic signed [19:0] s_data_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic signed [37:0] m_data_o,
  output logic signed [19:0] dsp_a_o,
  output logic signed [17:0] dsp_b_o,
  output logic               dsp_load_acc_o,
  output logic [2:0]         dsp_feedback_o,
  input  logic signed [37:0] dsp_z_i
);

  typedef enum logic [1:0] {IDLE, MAC, WAIT, OUT} state_t;

  state_t             state;
  logic signed [19:0] x [4];
  logic [1:0]         tap;
  logic [2:0]         wait_cnt;
  logic signed [17:0] coeff_sel;
  logic signed [37:0] z_cap;

  assign dsp_feedback_o = 3'b000;
  assign s_ready_o      = (state == IDLE) && !reset_i;

  // Coefficient for the tap currently being issued.
  always_comb begin
    coeff_sel = COEFF_0;
    case (tap)
      2'd1:    coeff_sel = COEFF_1;
      2'd2:    coeff_sel = COEFF_2;
      2'd3:    coeff_sel = COEFF_3;
      default: coeff_sel = COEFF_0;
    endcase
  end

`ifdef DSP_FIR_SEQ_SATURATE_EN
  localparam logic signed [37:0] SAT_MAX = 38'sd524287;
  localparam logic signed [37:0] SAT_MIN = -38'sd524288;

  // Clamp the accumulator to the signed 20-bit range before capture.
  always_comb begin
    z_cap = dsp_z_i;
    if (dsp_z_i > SAT_MAX)
      z_cap = SAT_MAX;
    else if (dsp_z_i < SAT_MIN)
      z_cap = SAT_MIN;
  end
`else
  assign z_cap = dsp_z_i;
`endif

  // Sequencer FSM; DSP port values are registered, so each tap appears on
  // the DSP one cycle after the MAC state cycle that selects it. WAIT is
  // therefore DSP_LATENCY+1 state cycles long to cover that extra register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      for (int i = 0; i < 4; i++) x[i] <= '0;
      tap            <= '0;
      wait_cnt       <= '0;
      m_valid_o      <= 1'b0;
      m_data_o       <= '0;
      dsp_a_o        <= '0;
      dsp_b_o        <= '0;
      dsp_load_acc_o <= 1'b0;
    end else begin
      dsp_a_o        <= '0;
      dsp_b_o        <= '0;
      dsp_load_acc_o <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid_i && s_ready_o) begin
            x[3]  <= x[2];
            x[2]  <= x[1];
            x[1]  <= x[0];
            x[0]  <= s_data_i;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          dsp_a_o        <= x[tap];
          dsp_b_o        <= coeff_sel;
          dsp_load_acc_o <= (tap == 2'd0);
          tap            <= tap + 2'd1;
          wait_cnt       <= DSP_LATENCY[2:0];
          if (tap == 2'd3)
            state <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            m_data_o  <= z_cap;
            m_valid_o <= 1'b1;
            state     <= OUT;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        OUT: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_fir_sequencer.sv
// Bench for dsp_fir_sequencer: two instances (coefficients 1,2,3,4 and
// 4,0,0,0) share stimulus, each driving a behavioural signed-MAC DSP model.
// Results are compared against a FIR sum over a sample history.
module tb_dsp_fir_sequencer;

  localparam int L = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               s_valid = 1'b0;
  logic signed [19:0] s_data  = '0;
  logic               m_ready = 1'b0;

  wire               s_ready_a, s_ready_b, m_valid_a, m_valid_b, load_a, load_b;
  wire signed [37:0] m_data_a, m_data_b;
  wire signed [19:0] dsp_a_a, dsp_a_b;
  wire signed [17:0] dsp_b_a, dsp_b_b;
  wire [2:0]         fb_a, fb_b;
  logic signed [37:0] z_a, z_b;

  dsp_fir_sequencer #(
    .COEFF_0(18'sd1), .COEFF_1(18'sd2), .COEFF_2(18'sd3), .COEFF_3(18'sd4),
    .DSP_LATENCY(L)
  ) u_dut_a (
    .clock_i(clk), .reset_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready_a), .s_data_i(s_data),
    .m_valid_o(m_valid_a), .m_ready_i(m_ready), .m_data_o(m_data_a),
    .dsp_a_o(dsp_a_a), .dsp_b_o(dsp_b_a), .dsp_load_acc_o(load_a),
    .dsp_feedback_o(fb_a), .dsp_z_i(z_a)
  );

  dsp_fir_sequencer #(
    .COEFF_0(18'sd4), .COEFF_1(18'sd0), .COEFF_2(18'sd0), .COEFF_3(18'sd0),
    .DSP_LATENCY(L)
  ) u_dut_b (
    .clock_i(clk), .reset_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready_b), .s_data_i(s_data),
    .m_valid_o(m_valid_b), .m_ready_i(m_ready), .m_data_o(m_data_b),
    .dsp_a_o(dsp_a_b), .dsp_b_o(dsp_b_b), .dsp_load_acc_o(load_b),
    .dsp_feedback_o(fb_b), .dsp_z_i(z_b)
  );

  // DSP models: signed MAC with a one-cycle registered output.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      z_a <= '0;
      z_b <= '0;
    end else begin
      z_a <= load_a ? dsp_a_a * dsp_b_a : z_a + dsp_a_a * dsp_b_a;
      z_b <= load_b ? dsp_a_b * dsp_b_b : z_b + dsp_a_b * dsp_b_b;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  longint hist [4];

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint fir_ref(input longint c0, input longint c1,
                                     input longint c2, input longint c3);
    longint s;
    s = c0 * hist[0] + c1 * hist[1] + c2 * hist[2] + c3 * hist[3];
`ifdef DSP_FIR_SEQ_SATURATE_EN
    if (s > 524287) s = 524287;
    if (s < -524288) s = -524288;
`endif
    return s;
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) hist[i] = 0;
  endtask

  task automatic push_hist(input longint d);
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = d;
  endtask

  // Present a sample and return just after the handshake edge.
  task automatic send_hs(input logic signed [19:0] d, output bit ok);
    int n;
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = s_ready_a;
    if (!ok) begin
      check_val("hs_timeout", 0, 1);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      push_hist(longint'(d));
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic txn(input logic signed [19:0] d, input int stall,
                     output logic signed [37:0] got_a, output logic signed [37:0] got_b);
    bit ok;
    int n, loads, load_at;
    longint exp_a, exp_b;
    got_a = 'x;
    got_b = 'x;
    m_ready = (stall == 0);
    send_hs(d, ok);
    if (!ok) return;
    // Here we are at the negedge following the handshake edge (n = 0).
    n = 0; loads = 0; load_at = -1;
    while (!m_valid_a && n < 30) begin
      if (load_a) begin loads++; load_at = n; end
      @(negedge clk);
      n++;
    end
    check_val("valid_latency", n, 5 + L);
    check_val("load_count", loads, 1);
    check_val("load_cycle", load_at, 1);
    check_val("valid_b", m_valid_b, 1);
    exp_a = fir_ref(1, 2, 3, 4);
    exp_b = fir_ref(4, 0, 0, 0);
    got_a = m_data_a;
    got_b = m_data_b;
    check_val("data_a", m_data_a, exp_a);
    check_val("data_b", m_data_b, exp_b);
    for (int i = 0; i < stall; i++) begin
      s_data  = 20'($urandom);
      s_valid = 1'b1;
      @(negedge clk);
      check_val("stall_valid", m_valid_a, 1);
      check_val("stall_data", m_data_a, exp_a);
      check_val("stall_ready", s_ready_a, 0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check_val("valid_drop", m_valid_a, 0);
    check_val("ready_back", s_ready_a, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_valid", m_valid_a, 0);
    check_val("rst_ready", s_ready_a, 0);
    check_val("rst_data", m_data_a, 0);
    clear_hist();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rel_ready", s_ready_a, 1);
  endtask

  initial begin
    logic signed [37:0] ga, gb;
    logic [37:0] ua;
    longint dir_exp [4];
    bit ok;
    dir_exp[0] = 10; dir_exp[1] = 40; dir_exp[2] = 100; dir_exp[3] = 200;
    clear_hist();

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("init_ready", s_ready_a, 0);
    check_val("init_valid", m_valid_a, 0);
    check_val("init_data", m_data_a, 0);
    check_val("init_dsp_a", dsp_a_a, 0);
    check_val("init_dsp_b", dsp_b_a, 0);
    check_val("init_load", load_a, 0);
    check_val("feedback", fb_a, 0);
    rst = 1'b0;
    #1 check_val("init_rel_ready", s_ready_a, 1);

    for (int i = 0; i < 4; i++) begin
      txn(20'(10 * (i + 1)), 0, ga, gb);
      check_val("directed", ga, dir_exp[i]);
    end

    txn(20'($urandom), 5, ga, gb);

    // Reset while tap 2 is in flight; the pending result must vanish.
    send_hs(20'sd777, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_valid", m_valid_a, 0);
    check_val("midrst_ready", s_ready_a, 0);
    check_val("midrst_dsp_a", dsp_a_a, 0);
    check_val("midrst_load", load_a, 0);
    clear_hist();
    @(negedge clk);
    rst = 1'b0;
    #1 check_val("midrst_rel_ready", s_ready_a, 1);
    txn(20'sd5, 0, ga, gb);
    check_val("after_rst_5", ga, 5);

    do_reset();
    txn(-20'sd524288, 0, ga, gb);
    ua = ga;
    check_val("neg_hex", {26'd0, ua}, 64'h3F_FFF8_0000);

    do_reset();
    txn(20'sd524287, 0, ga, gb);
`ifdef DSP_FIR_SEQ_SATURATE_EN
    check_val("sat_pos", gb, 524287);
`else
    check_val("sat_pos", gb, 2097148);
`endif

    for (int i = 0; i < 25; i++)
      txn(20'($urandom), int'($urandom_range(0, 3)), ga, gb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
